// File: rtl/ast_to_data.sv
// Avalon-ST sink that assembles one DATA_SYMBOLS packet into a parallel word.
// The word is held until the consumer takes it; malformed packets pulse err_o.
module ast_to_data #(
  parameter int BYTE_W           = 8,
  parameter int DATA_SYMBOLS     = 6,
  parameter int AST_SINK_SYMBOLS = 1,
  parameter bit AST_SINK_ORDER   = 1'b1,
  parameter int AST_SINK_EMPTY_W = (AST_SINK_SYMBOLS == 1) ? 1 : $clog2(AST_SINK_SYMBOLS)
) (
  input  logic                               clk_i,
  input  logic                               arst_i,
  input  logic [AST_SINK_SYMBOLS*BYTE_W-1:0] ast_sink_data_i,
  input  logic                               ast_sink_valid_i,
  output logic                               ast_sink_ready_o,
  input  logic [AST_SINK_EMPTY_W-1:0]        ast_sink_empty_i,
  input  logic                               ast_sink_startofpacket_i,
  input  logic                               ast_sink_endofpacket_i,
  output logic [DATA_SYMBOLS*BYTE_W-1:0]     data_o,
  output logic                               data_valid_o,
  input  logic                               data_ready_i,
  output logic                               err_o
);
  localparam int S         = AST_SINK_SYMBOLS;
  localparam int N_BEATS   = (DATA_SYMBOLS + S - 1) / S;
  localparam int DATA_MOD  = (DATA_SYMBOLS % S == 0) ? S : DATA_SYMBOLS % S;
  localparam int EXP_EMPTY = S - DATA_MOD;
  localparam int CNT_W     = $clog2(N_BEATS + 1);

  localparam logic [CNT_W-1:0]            LAST_BEAT = CNT_W'(N_BEATS - 1);
  localparam logic [AST_SINK_EMPTY_W-1:0] EXP_EMPTY_V = AST_SINK_EMPTY_W'(EXP_EMPTY);

  typedef enum logic [1:0] {IDLE, RECV, DROP, HOLD} state_t;

  state_t                               state_q, state_d;
  logic [CNT_W-1:0]                     beat_cnt_q, beat_cnt_d;
  logic [DATA_SYMBOLS-1:0][BYTE_W-1:0]  data_q, data_d;
  logic                                 valid_q, valid_d;
  logic                                 err_q, err_d;

  logic [S-1:0][BYTE_W-1:0] beat_sym, beat_ord;
  logic                     place;
  logic [CNT_W-1:0]         place_idx;
  logic                     sink_unused;

  assign beat_sym    = ast_sink_data_i;
  assign sink_unused = ^{ast_sink_empty_i, ast_sink_data_i};

  always_comb begin
    beat_ord = beat_sym;
    for (int i = 0; i < S; i++)
      beat_ord[i] = AST_SINK_ORDER ? beat_sym[S-1-i] : beat_sym[i];
  end

  // Beat k owns word symbols [k*S +: S]; the last beat naturally covers the
  // top DATA_MOD symbols from its low reordered symbols.
  always_comb begin
    data_d = data_q;
    if (place)
      for (int j = 0; j < DATA_SYMBOLS; j++)
        if (CNT_W'(j / S) == place_idx) data_d[j] = beat_ord[j % S];
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    valid_d    = valid_q;
    err_d      = 1'b0;
    place      = 1'b0;
    place_idx  = beat_cnt_q;
    if (state_q == HOLD) begin
      if (data_ready_i) begin
        valid_d    = 1'b0;
        beat_cnt_d = '0;
        state_d    = IDLE;
      end
    end else if (ast_sink_valid_i) begin
      if (ast_sink_startofpacket_i) begin
        // SOP always restarts; only an interrupted RECV counts as an error
        err_d      = (state_q == RECV);
        place_idx  = '0;
        beat_cnt_d = CNT_W'(1);
        if (N_BEATS == 1) begin
          place = 1'b1;
          if (ast_sink_endofpacket_i) begin
            state_d = HOLD;
            valid_d = 1'b1;
          end else begin
            state_d = DROP;
            err_d   = 1'b1;
          end
        end else if (ast_sink_endofpacket_i) begin
          state_d    = IDLE;
          err_d      = 1'b1;
          beat_cnt_d = '0;
        end else begin
          place   = 1'b1;
          state_d = RECV;
        end
      end else begin
        case (state_q)
          IDLE: begin
            err_d = 1'b1;
            if (!ast_sink_endofpacket_i) state_d = DROP;
          end
          DROP: if (ast_sink_endofpacket_i) state_d = IDLE;
          RECV: begin
            if (beat_cnt_q != LAST_BEAT) begin
              if (ast_sink_endofpacket_i) begin
                err_d      = 1'b1;
                state_d    = IDLE;
                beat_cnt_d = '0;
              end else begin
                place      = 1'b1;
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
              end
            end else if (!ast_sink_endofpacket_i) begin
              err_d      = 1'b1;
              state_d    = DROP;
              beat_cnt_d = '0;
            end else if (S > 1 && ast_sink_empty_i != EXP_EMPTY_V) begin
              err_d      = 1'b1;
              state_d    = IDLE;
              beat_cnt_d = '0;
            end else begin
              place   = 1'b1;
              state_d = HOLD;
              valid_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign ast_sink_ready_o = (state_q != HOLD);
  assign data_o           = data_q;
  assign data_valid_o     = valid_q;
  assign err_o            = err_q;
endmodule

// File: tb/tb_ast_to_data.sv
// Bench for ast_to_data: a 4-symbol big-endian sink (dut_a) and a 1-symbol
// little-endian sink (dut_b), both assembling 6-byte words.
module tb_ast_to_data;
  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] a_data;
  logic        a_valid, a_ready, a_sop, a_eop, a_dv, a_dready, a_err;
  logic [1:0]  a_empty;
  logic [47:0] a_word;

  logic [7:0]  b_data;
  logic        b_valid, b_ready, b_sop, b_eop, b_dv, b_dready, b_err;
  logic [0:0]  b_empty;
  logic [47:0] b_word;

  ast_to_data #(.BYTE_W(8), .DATA_SYMBOLS(6), .AST_SINK_SYMBOLS(4), .AST_SINK_ORDER(1'b1)) dut_a (
    .clk_i(clk), .arst_i(arst),
    .ast_sink_data_i(a_data), .ast_sink_valid_i(a_valid), .ast_sink_ready_o(a_ready),
    .ast_sink_empty_i(a_empty), .ast_sink_startofpacket_i(a_sop), .ast_sink_endofpacket_i(a_eop),
    .data_o(a_word), .data_valid_o(a_dv), .data_ready_i(a_dready), .err_o(a_err));

  ast_to_data #(.BYTE_W(8), .DATA_SYMBOLS(6), .AST_SINK_SYMBOLS(1), .AST_SINK_ORDER(1'b0)) dut_b (
    .clk_i(clk), .arst_i(arst),
    .ast_sink_data_i(b_data), .ast_sink_valid_i(b_valid), .ast_sink_ready_o(b_ready),
    .ast_sink_empty_i(b_empty), .ast_sink_startofpacket_i(b_sop), .ast_sink_endofpacket_i(b_eop),
    .data_o(b_word), .data_valid_o(b_dv), .data_ready_i(b_dready), .err_o(b_err));

  // err pulses seen per sink, sampled mid-cycle
  int a_errs = 0;
  int b_errs = 0;
  always @(negedge clk) begin
    if (a_err === 1'b1) a_errs++;
    if (b_err === 1'b1) b_errs++;
  end

  // Sender-side model: word symbol k*4+i goes to beat symbol 3-i (big-endian)
  function automatic logic [31:0] a_pack(input logic [47:0] w, input int k, input logic [31:0] fill);
    logic [31:0] b;
    b = fill;
    for (int i = 0; i < 4; i++)
      if (k * 4 + i < 6) b[(3 - i) * 8 +: 8] = w[(k * 4 + i) * 8 +: 8];
    return b;
  endfunction

  function automatic logic [47:0] rand_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[47:0];
  endfunction

  task automatic a_beat(input logic [31:0] d, input logic sop, input logic eop, input logic [1:0] emp);
    int t;
    logic [31:0] r;
    t = 0;
    a_data = d; a_sop = sop; a_eop = eop; a_empty = emp; a_valid = 1'b1;
    while (a_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      $display("FAIL a_beat_accept ready=%b required 1", a_ready);
      $fatal(1, "sink A never accepted a beat");
    end
    @(negedge clk);
    r = $urandom;
    a_valid = 1'b0; a_data = $urandom; a_sop = r[0]; a_eop = r[1]; a_empty = r[3:2];
  endtask

  task automatic b_beat(input logic [7:0] d, input logic sop, input logic eop);
    int t;
    logic [31:0] r;
    t = 0;
    b_data = d; b_sop = sop; b_eop = eop; b_empty = 1'b0; b_valid = 1'b1;
    while (b_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      $display("FAIL b_beat_accept ready=%b required 1", b_ready);
      $fatal(1, "sink B never accepted a beat");
    end
    @(negedge clk);
    r = $urandom;
    b_valid = 1'b0; b_data = r[7:0]; b_sop = r[8]; b_eop = r[9]; b_empty = r[10];
  endtask

  task automatic a_send(input logic [47:0] w);
    a_beat(a_pack(w, 0, $urandom), 1'b1, 1'b0, 2'd0);
    a_beat(a_pack(w, 1, $urandom), 1'b0, 1'b1, 2'd2);
  endtask

  task automatic b_send(input logic [47:0] w);
    for (int k = 0; k < 6; k++) b_beat(w[k*8 +: 8], k == 0, k == 5);
  endtask

  task automatic a_take(output logic [47:0] w, output logic got);
    int t;
    t = 0;
    while (a_dv !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    got = (a_dv === 1'b1); w = a_word;
    a_dready = 1'b1; @(negedge clk); a_dready = 1'b0;
  endtask

  task automatic b_take(output logic [47:0] w, output logic got);
    int t;
    t = 0;
    while (b_dv !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    got = (b_dv === 1'b1); w = b_word;
    b_dready = 1'b1; @(negedge clk); b_dready = 1'b0;
  endtask

  task automatic test_reset;
    arst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (a_dv !== 1'b0 || a_err !== 1'b0 || a_word !== 48'h0) begin
      errors++; $display("FAIL reset_a dv=%b err=%b word=%h required 0/0/0", a_dv, a_err, a_word);
    end
    checks++;
    if (b_dv !== 1'b0 || b_err !== 1'b0 || b_word !== 48'h0) begin
      errors++; $display("FAIL reset_b dv=%b err=%b word=%h required 0/0/0", b_dv, b_err, b_word);
    end
    arst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready a=%b b=%b required 1/1", a_ready, b_ready);
    end
    a_errs = 0; b_errs = 0;
  endtask

  task automatic test_basic_be;
    int e0;
    e0 = a_errs;
    a_beat(32'h01020304, 1'b1, 1'b0, 2'd0);
    a_beat(32'h05060000, 1'b0, 1'b1, 2'd2);
    checks++;
    if (a_dv !== 1'b1 || a_word !== 48'h060504030201) begin
      errors++; $display("FAIL basic_latency dv=%b word=%h required 1 060504030201", a_dv, a_word);
    end
    a_dready = 1'b1; @(negedge clk); a_dready = 1'b0;
    checks++;
    if (a_dv !== 1'b0 || a_ready !== 1'b1) begin
      errors++; $display("FAIL basic_release dv=%b ready=%b required 0/1", a_dv, a_ready);
    end
    @(negedge clk);
    checks++;
    if (a_errs !== e0) begin
      errors++; $display("FAIL basic_err pulses=%0d required 0", a_errs - e0);
    end
  endtask

  task automatic test_hold_stall;
    logic [47:0] w;
    int bad;
    w = 48'h060504030201; bad = 0;
    a_send(w);
    for (int c = 0; c < 5; c++) begin
      if (a_dv !== 1'b1 || a_word !== w || a_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL hold_stable bad_cycles=%0d dv=%b ready=%b word=%h required 0", bad, a_dv, a_ready, a_word);
    end
    a_dready = 1'b1; @(negedge clk); a_dready = 1'b0;
    checks++;
    if (a_ready !== 1'b1 || a_dv !== 1'b0) begin
      errors++; $display("FAIL hold_release ready=%b dv=%b required 1/0", a_ready, a_dv);
    end
  endtask

  task automatic test_sop_restart;
    logic [47:0] wx, wy, got_w;
    logic got;
    int e0;
    wx = 48'hAABBCCDDEEFF; wy = 48'h112233445566; e0 = a_errs;
    a_beat(a_pack(wx, 0, 32'h0), 1'b1, 1'b0, 2'd0);
    a_send(wy);
    a_take(got_w, got);
    checks++;
    if (!got || got_w !== wy) begin
      errors++; $display("FAIL sop_restart_word got=%b word=%h required %h", got, got_w, wy);
    end
    @(negedge clk);
    checks++;
    if (a_errs - e0 !== 1) begin
      errors++; $display("FAIL sop_restart_err pulses=%0d required 1", a_errs - e0);
    end
  endtask

  task automatic test_eop_beat0;
    int e0, seen;
    e0 = a_errs; seen = 0;
    a_beat(32'hDEADBEEF, 1'b1, 1'b1, 2'd0);
    for (int c = 0; c < 4; c++) begin
      if (a_dv !== 1'b0) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0 || a_errs - e0 !== 1) begin
      errors++; $display("FAIL eop_beat0 dv_cycles=%0d pulses=%0d required 0/1", seen, a_errs - e0);
    end
  endtask

  task automatic test_bad_empty;
    logic [47:0] w, got_w;
    logic got;
    int e0, seen;
    w = 48'h0A0B0C0D0E0F; e0 = a_errs; seen = 0;
    a_beat(a_pack(w, 0, 32'h0), 1'b1, 1'b0, 2'd0);
    a_beat(a_pack(w, 1, 32'h0), 1'b0, 1'b1, 2'd1);
    for (int c = 0; c < 3; c++) begin
      if (a_dv !== 1'b0) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0 || a_errs - e0 !== 1) begin
      errors++; $display("FAIL bad_empty dv_cycles=%0d pulses=%0d required 0/1", seen, a_errs - e0);
    end
    a_send(w);
    a_take(got_w, got);
    checks++;
    if (!got || got_w !== w) begin
      errors++; $display("FAIL bad_empty_next got=%b word=%h required %h", got, got_w, w);
    end
  endtask

  task automatic test_missing_eop;
    logic [47:0] w, got_w;
    logic got;
    int e0, seen;
    w = 48'h5A5B5C5D5E5F; e0 = a_errs; seen = 0;
    a_beat(a_pack(w, 0, 32'h0), 1'b1, 1'b0, 2'd0);
    a_beat(a_pack(w, 1, 32'h0), 1'b0, 1'b0, 2'd2);
    a_beat(32'h12345678, 1'b0, 1'b0, 2'd0);
    a_beat(32'h9ABCDEF0, 1'b0, 1'b1, 2'd0);
    for (int c = 0; c < 3; c++) begin
      if (a_dv !== 1'b0) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0 || a_errs - e0 !== 1) begin
      errors++; $display("FAIL missing_eop dv_cycles=%0d pulses=%0d required 0/1", seen, a_errs - e0);
    end
    w = 48'hC1C2C3C4C5C6;
    a_send(w);
    a_take(got_w, got);
    checks++;
    if (!got || got_w !== w) begin
      errors++; $display("FAIL missing_eop_next got=%b word=%h required %h", got, got_w, w);
    end
  endtask

  task automatic test_reset_mid;
    logic [47:0] w, got_w;
    logic got;
    w = 48'h313233343536;
    a_beat(a_pack(w, 0, 32'h0), 1'b1, 1'b0, 2'd0);
    arst = 1'b1;
    #1;
    checks++;
    if (a_word !== 48'h0 || a_dv !== 1'b0 || a_err !== 1'b0) begin
      errors++; $display("FAIL reset_mid word=%h dv=%b err=%b required 0/0/0", a_word, a_dv, a_err);
    end
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    w = 48'hF1E2D3C4B5A6;
    a_send(w);
    a_take(got_w, got);
    checks++;
    if (!got || got_w !== w) begin
      errors++; $display("FAIL reset_mid_next got=%b word=%h required %h", got, got_w, w);
    end
  endtask

  task automatic test_s1_le;
    logic [47:0] w2, got_w;
    logic got;
    int e0;
    e0 = b_errs;
    b_send(48'h060504030201);
    checks++;
    if (b_dv !== 1'b1 || b_word !== 48'h060504030201) begin
      errors++; $display("FAIL s1_word dv=%b word=%h required 1 060504030201", b_dv, b_word);
    end
    b_dready = 1'b1; @(negedge clk); b_dready = 1'b0;
    w2 = 48'hA1A2A3A4A5A6;
    b_send(w2);
    b_take(got_w, got);
    checks++;
    if (!got || got_w !== w2) begin
      errors++; $display("FAIL s1_back_to_back got=%b word=%h required %h", got, got_w, w2);
    end
    @(negedge clk);
    checks++;
    if (b_errs !== e0) begin
      errors++; $display("FAIL s1_err pulses=%0d required 0", b_errs - e0);
    end
  endtask

  task automatic test_random;
    logic [47:0] w, got_w;
    logic got;
    int ea, eb;
    ea = a_errs; eb = b_errs;
    for (int p = 0; p < 20; p++) begin
      w = rand_word();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a_send(w);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a_take(got_w, got);
      checks++;
      if (!got || got_w !== w) begin
        errors++; $display("FAIL random_a pkt=%0d got=%b word=%h required %h", p, got, got_w, w);
      end
      w = rand_word();
      b_send(w);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      b_take(got_w, got);
      checks++;
      if (!got || got_w !== w) begin
        errors++; $display("FAIL random_b pkt=%0d got=%b word=%h required %h", p, got, got_w, w);
      end
    end
    @(negedge clk);
    checks++;
    if (a_errs !== ea || b_errs !== eb) begin
      errors++; $display("FAIL random_err a=%0d b=%0d required 0/0", a_errs - ea, b_errs - eb);
    end
  endtask

  initial begin
    a_valid = 1'b0; a_data = '0; a_sop = 1'b0; a_eop = 1'b0; a_empty = '0; a_dready = 1'b0;
    b_valid = 1'b0; b_data = '0; b_sop = 1'b0; b_eop = 1'b0; b_empty = '0; b_dready = 1'b0;
    @(negedge clk);
    test_reset;
    test_basic_be;
    test_hold_stall;
    test_sop_restart;
    test_eop_beat0;
    test_bad_empty;
    test_missing_eop;
    test_reset_mid;
    test_s1_le;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
